// File: rtl/stump_sequencer_pkg.sv
// ============================================================
// stump_sequencer_pkg : state, opcode and condition encodings
// Rev 1.0
// ============================================================
`default_nettype none

package stump_sequencer_pkg;

  localparam logic [1:0] ST_FETCH   = 2'b00;
  localparam logic [1:0] ST_EXECUTE = 2'b01;
  localparam logic [1:0] ST_MEMORY  = 2'b10;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_LDST = 3'b110;
  localparam logic [2:0] OP_BCC  = 3'b111;

  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_NV = 4'd1;
  localparam logic [3:0] CC_HI = 4'd2;
  localparam logic [3:0] CC_LS = 4'd3;
  localparam logic [3:0] CC_CC = 4'd4;
  localparam logic [3:0] CC_CS = 4'd5;
  localparam logic [3:0] CC_NE = 4'd6;
  localparam logic [3:0] CC_EQ = 4'd7;
  localparam logic [3:0] CC_VC = 4'd8;
  localparam logic [3:0] CC_VS = 4'd9;
  localparam logic [3:0] CC_PL = 4'd10;
  localparam logic [3:0] CC_MI = 4'd11;
  localparam logic [3:0] CC_GE = 4'd12;
  localparam logic [3:0] CC_LT = 4'd13;
  localparam logic [3:0] CC_GT = 4'd14;
  localparam logic [3:0] CC_LE = 4'd15;

  typedef struct packed {
    logic [2:0] op;
    logic       is_imm;
    logic       s_bit;
    logic [2:0] dest;
    logic [2:0] src_a;
    logic [1:0] shift;
  } ir_fields_t;

  // Immediate forms have no shift field, so the shifter is forced to pass-through.
  function automatic ir_fields_t decode_ir(input logic [15:0] ir);
    ir_fields_t f;
    f.op     = ir[15:13];
    f.is_imm = ir[12];
    f.s_bit  = ir[11];
    f.dest   = ir[10:8];
    f.src_a  = ir[7:5];
    f.shift  = ir[12] ? 2'b00 : ir[1:0];
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stump_cond_eval.sv
// ============================================================
// stump_cond_eval : branch condition evaluation from {N,Z,V,C}
// Rev 1.0
// ============================================================
`default_nettype none

module stump_cond_eval
  import stump_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, v, c;
  assign n = flags[3];
  assign z = flags[2];
  assign v = flags[1];
  assign c = flags[0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_AL: taken = 1'b1;
      CC_NV: taken = 1'b0;
      CC_HI: taken = !c && !z;
      CC_LS: taken = c || z;
      CC_CC: taken = !c;
      CC_CS: taken = c;
      CC_NE: taken = !z;
      CC_EQ: taken = z;
      CC_VC: taken = !v;
      CC_VS: taken = v;
      CC_PL: taken = !n;
      CC_MI: taken = n;
      CC_GE: taken = (n == v);
      CC_LT: taken = (n != v);
      CC_GT: taken = !z && (n == v);
      CC_LE: taken = z || (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/stump_sequencer.sv
// ============================================================
// stump_sequencer : multi-cycle FETCH/EXECUTE/MEMORY control FSM
// Rev 1.0
// ============================================================
`default_nettype none

module stump_sequencer
  import stump_sequencer_pkg::*;
#(
  parameter logic [2:0] PC_REG  = 3'd7,
  parameter bit         WAIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
  input  logic        mem_ready,
  output logic [1:0]  state,
  output logic        ir_en,
  output logic        pc_inc,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic        addr_sel,
  output logic        addr_en,
  output logic [2:0]  alu_func,
  output logic        imm_sel,
  output logic        ext_op,
  output logic [1:0]  shift_op,
  output logic        cc_en,
  output logic        reg_write,
  output logic        wdata_sel,
  output logic [2:0]  dest,
  output logic [2:0]  src_a
);

  logic [1:0] r_state;
  logic [1:0] w_next;
  ir_fields_t w_f;
  logic       w_rdy;
  logic       w_taken;

  assign w_f   = decode_ir(ir);
  assign w_rdy = WAIT_EN ? mem_ready : 1'b1;

  stump_cond_eval u_cond (
    .cond  (ir[11:8]),
    .flags (flags),
    .taken (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  // Every output is gated by rst so an aborted instruction cannot leave a partial write.
  always_comb begin
    w_next    = r_state;
    state     = ST_FETCH;
    ir_en     = 1'b0;
    pc_inc    = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    addr_sel  = 1'b0;
    addr_en   = 1'b0;
    alu_func  = 3'b000;
    imm_sel   = 1'b0;
    ext_op    = 1'b0;
    shift_op  = 2'b00;
    cc_en     = 1'b0;
    reg_write = 1'b0;
    wdata_sel = 1'b0;
    dest      = 3'd0;
    src_a     = 3'd0;
    if (!rst) begin
      state = r_state;
      case (r_state)
        ST_FETCH: begin
          mem_ren = 1'b1;
          if (w_rdy) begin
            ir_en  = 1'b1;
            pc_inc = 1'b1;
            w_next = ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          w_next = ST_FETCH;
          if (w_f.op == OP_LDST) begin
            alu_func = OP_LDST;
            src_a    = w_f.src_a;
            imm_sel  = w_f.is_imm;
            shift_op = w_f.shift;
            addr_en  = 1'b1;
            w_next   = ST_MEMORY;
          end else if (w_f.op == OP_BCC) begin
            if (w_f.is_imm) begin
              alu_func = OP_BCC;
              src_a    = PC_REG;
              imm_sel  = 1'b1;
              ext_op   = 1'b1;
              if (w_taken) begin
                reg_write = 1'b1;
                dest      = PC_REG;
              end
            end
          end else begin
            alu_func  = w_f.op;
            src_a     = w_f.src_a;
            imm_sel   = w_f.is_imm;
            shift_op  = w_f.shift;
            reg_write = 1'b1;
            dest      = w_f.dest;
            cc_en     = w_f.s_bit;
          end
        end
        ST_MEMORY: begin
          addr_sel = 1'b1;
          if (w_f.s_bit) mem_wen = 1'b1;
          else           mem_ren = 1'b1;
          if (w_rdy) begin
            w_next = ST_FETCH;
            if (!w_f.s_bit) begin
              reg_write = 1'b1;
              dest      = w_f.dest;
              wdata_sel = 1'b1;
            end
          end
        end
        default: w_next = ST_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stump_sequencer.sv
// ============================================================
// tb_stump_sequencer : vector, corner-case and random checks
// Rev 1.0
// ============================================================
`default_nettype none

module tb_stump_sequencer;
  import stump_sequencer_pkg::*;

  typedef struct packed {
    logic [1:0] state;
    logic       ir_en, pc_inc, mem_ren, mem_wen, addr_sel, addr_en;
    logic [2:0] alu_func;
    logic       imm_sel, ext_op;
    logic [1:0] shift_op;
    logic       cc_en, reg_write, wdata_sel;
    logic [2:0] dest, src_a;
  } outs_t;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  flags;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, mem_ready;
  logic [15:0] ir;
  logic [3:0]  flags;
  int total = 0;
  int bad   = 0;

  logic [1:0] d0_state, d1_state, d0_shift, d1_shift;
  logic d0_ir_en, d0_pc_inc, d0_ren, d0_wen, d0_asel, d0_aen, d0_imm, d0_ext, d0_cc, d0_rw, d0_wsel;
  logic d1_ir_en, d1_pc_inc, d1_ren, d1_wen, d1_asel, d1_aen, d1_imm, d1_ext, d1_cc, d1_rw, d1_wsel;
  logic [2:0] d0_alu, d0_dest, d0_srca, d1_alu, d1_dest, d1_srca;
  outs_t a0, a1;

  logic [3:0] ce_cond, ce_flags;
  logic       ce_taken;

  always #5 clk = ~clk;

  stump_sequencer #(.PC_REG(3'd7), .WAIT_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .ir(ir), .flags(flags), .mem_ready(mem_ready),
    .state(d0_state), .ir_en(d0_ir_en), .pc_inc(d0_pc_inc), .mem_ren(d0_ren), .mem_wen(d0_wen),
    .addr_sel(d0_asel), .addr_en(d0_aen), .alu_func(d0_alu), .imm_sel(d0_imm), .ext_op(d0_ext),
    .shift_op(d0_shift), .cc_en(d0_cc), .reg_write(d0_rw), .wdata_sel(d0_wsel),
    .dest(d0_dest), .src_a(d0_srca));

  stump_sequencer #(.PC_REG(3'd7), .WAIT_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .ir(ir), .flags(flags), .mem_ready(mem_ready),
    .state(d1_state), .ir_en(d1_ir_en), .pc_inc(d1_pc_inc), .mem_ren(d1_ren), .mem_wen(d1_wen),
    .addr_sel(d1_asel), .addr_en(d1_aen), .alu_func(d1_alu), .imm_sel(d1_imm), .ext_op(d1_ext),
    .shift_op(d1_shift), .cc_en(d1_cc), .reg_write(d1_rw), .wdata_sel(d1_wsel),
    .dest(d1_dest), .src_a(d1_srca));

  stump_cond_eval u_ce (.cond(ce_cond), .flags(ce_flags), .taken(ce_taken));

  assign a0 = {d0_state, d0_ir_en, d0_pc_inc, d0_ren, d0_wen, d0_asel, d0_aen, d0_alu, d0_imm,
               d0_ext, d0_shift, d0_cc, d0_rw, d0_wsel, d0_dest, d0_srca};
  assign a1 = {d1_state, d1_ir_en, d1_pc_inc, d1_ren, d1_wen, d1_asel, d1_aen, d1_alu, d1_imm,
               d1_ext, d1_shift, d1_cc, d1_rw, d1_wsel, d1_dest, d1_srca};

  // ---------------- reference model ----------------
  function automatic logic model_taken(input logic [3:0] cond, input logic [3:0] f);
    logic n = f[3], z = f[2], v = f[1], c = f[0];
    case (cond)
      4'd0:  return 1'b1;
      4'd1:  return 1'b0;
      4'd2:  return !c && !z;
      4'd3:  return c || z;
      4'd4:  return !c;
      4'd5:  return c;
      4'd6:  return !z;
      4'd7:  return z;
      4'd8:  return !v;
      4'd9:  return v;
      4'd10: return !n;
      4'd11: return n;
      4'd12: return n == v;
      4'd13: return n != v;
      4'd14: return !z && (n == v);
      default: return z || (n != v);
    endcase
  endfunction

  function automatic outs_t fetch_exp(input logic rdy);
    outs_t e = '0;
    e.mem_ren = 1'b1;
    e.ir_en   = rdy;
    e.pc_inc  = rdy;
    return e;
  endfunction

  function automatic outs_t exec_exp(input logic [15:0] i, input logic [3:0] f);
    outs_t e = '0;
    logic [2:0] op = i[15:13];
    logic t = i[12];
    e.state = 2'd1;
    if (op <= 3'd5) begin
      e.alu_func = op;  e.src_a = i[7:5];  e.imm_sel = t;
      e.shift_op = t ? 2'b00 : i[1:0];
      e.reg_write = 1'b1;  e.dest = i[10:8];  e.cc_en = i[11];
    end else if (op == 3'd6) begin
      e.alu_func = 3'd6;  e.src_a = i[7:5];  e.imm_sel = t;
      e.shift_op = t ? 2'b00 : i[1:0];
      e.addr_en = 1'b1;
    end else if (t) begin
      e.alu_func = 3'd7;  e.src_a = 3'd7;  e.imm_sel = 1'b1;  e.ext_op = 1'b1;
      if (model_taken(i[11:8], f)) begin
        e.reg_write = 1'b1;  e.dest = 3'd7;
      end
    end
    return e;
  endfunction

  function automatic outs_t mem_exp(input logic [15:0] i, input logic rdy);
    outs_t e = '0;
    e.state = 2'd2;
    e.addr_sel = 1'b1;
    if (i[11]) e.mem_wen = 1'b1;
    else begin
      e.mem_ren = 1'b1;
      if (rdy) begin
        e.reg_write = 1'b1;  e.wdata_sel = 1'b1;  e.dest = i[10:8];
      end
    end
    return e;
  endfunction

  function automatic outs_t ex(input logic [2:0] alu, input logic [2:0] sa, input logic imm,
                               input logic ext, input logic [1:0] sh, input logic cc,
                               input logic rw, input logic aen, input logic [2:0] d);
    outs_t e = '0;
    e.state = 2'd1;  e.alu_func = alu;  e.src_a = sa;  e.imm_sel = imm;  e.ext_op = ext;
    e.shift_op = sh;  e.cc_en = cc;  e.reg_write = rw;  e.addr_en = aen;  e.dest = d;
    return e;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input outs_t got, input outs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input outs_t exp);
    @(negedge clk);
    chk(nm, a0, exp);
    tick();
  endtask

  task automatic run_instr(input logic [15:0] i, input logic [3:0] f, input int fw, input int mw,
                           input string nm, input logic use_tab, input outs_t tab);
    ir = i;
    flags = f;
    for (int k = 0; k < fw; k++) begin
      mem_ready = 1'b0;
      cyc({nm, "_fetch_wait"}, fetch_exp(1'b0));
    end
    mem_ready = 1'b1;
    cyc({nm, "_fetch"}, fetch_exp(1'b1));
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({nm, "_exec"}, a0, exec_exp(i, f));
    if (use_tab) chk({nm, "_exec_tab"}, a0, tab);
    tick();
    if (i[15:13] == 3'b110) begin
      for (int k = 0; k < mw; k++) begin
        mem_ready = 1'b0;
        cyc({nm, "_mem_wait"}, mem_exp(i, 1'b0));
      end
      mem_ready = 1'b1;
      cyc({nm, "_mem"}, mem_exp(i, 1'b1));
    end
  endtask

  vec_t tab[8];

  initial begin
    tab[0] = '{16'h2A4B, 4'h0, ex(3'd1, 3'd2, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 3'd2)};
    tab[1] = '{16'h1A4B, 4'h0, ex(3'd0, 3'd2, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd2)};
    tab[2] = '{16'hC305, 4'h0, ex(3'd6, 3'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 3'd0)};
    tab[3] = '{16'hF7FE, 4'h4, ex(3'd7, 3'd7, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 3'd7)};
    tab[4] = '{16'hF7FE, 4'h0, ex(3'd7, 3'd7, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0)};
    tab[5] = '{16'hE000, 4'hF, ex(3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0)};
    tab[6] = '{16'hA5F1, 4'h0, ex(3'd5, 3'd7, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd5)};
    tab[7] = '{16'hF1FF, 4'hF, ex(3'd7, 3'd7, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0)};

    // Reset with live-looking inputs: everything must stay quiet.
    rst = 1'b1;  mem_ready = 1'b1;  ir = 16'hC305;  flags = 4'hF;
    tick();
    @(negedge clk);
    chk("reset_dut0", a0, '0);
    chk("reset_dut1", a1, '0);
    tick();
    rst = 1'b0;

    foreach (tab[i]) run_instr(tab[i].ir, tab[i].flags, 0, 0, $sformatf("tab%0d", i), 1'b1, tab[i].exp);

    run_instr(16'hC305, 4'h0, 1, 2, "ld_wait", 1'b0, '0);
    run_instr(16'hCB05, 4'h0, 0, 1, "st_wait", 1'b0, '0);

    // Reset in the middle of a store's memory wait.
    ir = 16'hCB05;  flags = 4'h0;  mem_ready = 1'b1;
    cyc("rstmid_fetch", fetch_exp(1'b1));
    mem_ready = 1'b0;
    cyc("rstmid_exec", exec_exp(16'hCB05, 4'h0));
    cyc("rstmid_mem", mem_exp(16'hCB05, 1'b0));
    rst = 1'b1;
    for (int k = 0; k < 3; k++) cyc("rstmid_held", '0);
    rst = 1'b0;
    cyc("rstmid_after", fetch_exp(1'b0));

    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        ce_cond = 4'(c);
        ce_flags = 4'(f);
        #1;
        total++;
        if (ce_taken !== model_taken(4'(c), 4'(f))) begin
          bad++;
          $display("FAIL cond_sweep c=%0d f=%h: got=%b expected=%b", c, f, ce_taken,
                   model_taken(4'(c), 4'(f)));
        end
      end
    end

    for (int n = 0; n < 150; n++) begin
      run_instr(16'($urandom), 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                "rand", 1'b0, '0);
    end

    // WAIT_EN=0 instance ignores a low mem_ready; WAIT_EN=1 instance keeps waiting.
    rst = 1'b1;
    tick();
    rst = 1'b0;  mem_ready = 1'b0;  ir = 16'hC305;  flags = 4'h0;
    @(negedge clk);
    chk("nowait_fetch", a1, fetch_exp(1'b1));
    chk("wait_fetch_stall", a0, fetch_exp(1'b0));
    tick();
    @(negedge clk);
    chk("nowait_exec", a1, exec_exp(16'hC305, 4'h0));
    tick();
    @(negedge clk);
    chk("nowait_mem", a1, mem_exp(16'hC305, 1'b1));
    tick();
    @(negedge clk);
    chk("nowait_refetch", a1, fetch_exp(1'b1));
    chk("wait_still_fetch", a0, fetch_exp(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
